// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - receive-side host handshake bundle for uart_rx_param
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_rd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_empty;
    logic                 rx_valid;
    logic                 rx_ferror;
    logic                 rx_perror;
    logic                 rx_overrun;

    modport master (
        input  rx_rd,
        output rx_data, rx_empty, rx_valid, rx_ferror, rx_perror, rx_overrun
    );

    modport slave (
        output rx_rd,
        input  rx_data, rx_empty, rx_valid, rx_ferror, rx_perror, rx_overrun
    );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with majority vote and output buffer (UART_RX_FIFO_EN selects FIFO)
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic              rx_en,
    input  logic              rxd,
    uart_rx_param_if.master   bus
);
    localparam int M  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_M1   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_M    = CW'(M);
    localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    // Reject configurations the datapath is not built for.
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_rx_param: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, rxs_q, prev_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 frame_end, frame_ferr;
    logic                 vote, exp_par, at_dec, at_end;
    logic                 rd_acc, good, wr_en, overrun, buf_full, buf_empty;

    // Third vote sample is the live synchronised line at the decision tick.
    assign vote    = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    assign exp_par = (PARITY == 2) ? ~^shift_q : ^shift_q;
    assign at_dec  = (cnt_q == CNT_DEC);
    assign at_end  = (cnt_q == CNT_LAST);

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
        end
    end

    // Line value at the previous oversample tick, for start-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else if (sample_en) begin
            prev_q <= rxs_q;
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Frame sequencing; everything advances only on an oversample tick.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_end  = 1'b0;
        frame_ferr = 1'b0;
        if (sample_en) begin
            if (state_q == S_IDLE) begin
                // Only a 1->0 transition starts a frame, so a stuck-low line never retriggers.
                if (rx_en && prev_q && !rxs_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end else if (!rx_en) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = at_end ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_M1) s0_d = rxs_q;
                if (cnt_q == CNT_M)  s1_d = rxs_q;
                case (state_q)
                    S_START: begin
                        if (at_dec && vote) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else if (at_end) begin
                            state_d = S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (at_dec) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                        if (at_end) begin
                            bit_d = bit_q + 1'b1;
                            if (bit_q == BIT_LAST) state_d = (PARITY == 0) ? S_STOP : S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        if (at_dec) perr_d = (vote != exp_par);
                        if (at_end) state_d = S_STOP;
                    end
                    S_STOP: begin
                        if (at_dec) begin
                            if (!vote) ferr_d = 1'b1;
                            // Finish mid-bit so a start edge right after the stop bit is not missed.
                            if (stop_q == STOP_LAST) begin
                                frame_end  = 1'b1;
                                frame_ferr = ferr_q | ~vote;
                                state_d    = S_IDLE;
                                cnt_d      = '0;
                            end
                        end
                        if (at_end) stop_d = stop_q + 1'b1;
                    end
                    default: begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    assign rd_acc  = bus.rx_rd & ~buf_empty;
    assign good    = frame_end & ~frame_ferr & ~perr_q;
    assign wr_en   = good & (~buf_full | rd_acc);
    assign overrun = good & buf_full & ~rd_acc;

    assign bus.rx_valid   = wr_en;
    assign bus.rx_ferror  = frame_end & frame_ferr;
    assign bus.rx_perror  = frame_end & perr_q;
    assign bus.rx_overrun = overrun;
    assign bus.rx_empty   = buf_empty;

`ifdef UART_RX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] data_q;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [PW:0]          count_q;

    assign buf_full    = (count_q == (PW + 1)'(FIFO_DEPTH));
    assign buf_empty   = (count_q == '0);
    assign rd_ptr_d    = rd_ptr_q + {{(PW - 1){1'b0}}, rd_acc};
    assign bus.rx_data = data_q;

    // Circular FIFO; the head register bypasses a write that lands at the new head.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_q + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, rd_acc};
            data_q   <= (wr_en && (wr_ptr_q == rd_ptr_d)) ? shift_q : mem_q[rd_ptr_d];
        end
    end
`else
    logic [DATA_BITS-1:0] hold_q;
    logic                 full_q;

    assign buf_full    = full_q;
    assign buf_empty   = ~full_q;
    assign bus.rx_data = hold_q;

    // Single holding register; a pop in the write cycle frees it for the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else if (wr_en) begin
            hold_q <= shift_q;
            full_q <= 1'b1;
        end else if (rd_acc) begin
            full_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized self-checking bench for uart_rx_param against a frame-level model
module tb_uart_rx_param;
    localparam int DB  = 8;
    localparam int PAR = 1;
    localparam int SB  = 1;
    localparam int OS  = 16;
    localparam int DEPTH_CFG = 4;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = DEPTH_CFG;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic reset, sample_en, rx_en, rxd;

    uart_rx_param_if #(.DATA_BITS(DB)) bus ();

    uart_rx_param #(
        .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH_CFG)
    ) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .rx_en(rx_en), .rxd(rxd), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_valid = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
    logic [DB-1:0] model_q[$];

    // Pulse tallies, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            n_valid <= n_valid + int'(bus.rx_valid);
            n_ferr  <= n_ferr  + int'(bus.rx_ferror);
            n_perr  <= n_perr  + int'(bus.rx_perror);
            n_ovr   <= n_ovr   + int'(bus.rx_overrun);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1 sample_en = 1'b1;
        @(posedge clk); #1 sample_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    // Drives a frame bit by bit; optional one-tick spike, rx_en drop, or truncation.
    task automatic send_frame(input logic [DB-1:0] d, input bit bad_par, input bit bad_stop,
                              input int spike_bit, input int drop_bit, input int nbits);
        logic bits[$];
        logic v;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (PAR != 0) bits.push_back(((PAR == 2) ? ~^d : ^d) ^ bad_par);
        for (int s = 0; s < SB; s++) bits.push_back((bad_stop && s == SB - 1) ? 1'b0 : 1'b1);
        for (int b = 0; b < bits.size() && b < nbits; b++) begin
            for (int t = 0; t < OS; t++) begin
                v = bits[b];
                if (b == spike_bit && t == 8) v = ~v;
                if (b == drop_bit && t == 0) rx_en = 1'b0;
                rxd = v;
                tick();
            end
        end
        rxd = 1'b1;
    endtask

    task automatic do_frame(input string tag, input logic [DB-1:0] d, input bit bad_par,
                            input bit bad_stop, input int spike_bit);
        int v0, f0, p0, o0;
        int ev, ef, ep, eo;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
        ef = bad_stop ? 1 : 0;
        ep = (bad_par && PAR != 0) ? 1 : 0;
        ev = 0; eo = 0;
        if (ef == 0 && ep == 0) begin
            if (model_q.size() == DEPTH) eo = 1;
            else begin
                ev = 1;
                model_q.push_back(d);
            end
        end
        send_frame(d, bad_par, bad_stop, spike_bit, -1, 99);
        idle(4);
        check({tag, ".valid"},   n_valid - v0, ev);
        check({tag, ".ferror"},  n_ferr - f0,  ef);
        check({tag, ".perror"},  n_perr - p0,  ep);
        check({tag, ".overrun"}, n_ovr - o0,   eo);
        check({tag, ".empty"},   bus.rx_empty, (model_q.size() == 0));
        if (model_q.size() != 0) check({tag, ".head"}, bus.rx_data, model_q[0]);
    endtask

    task automatic read_one(input string tag);
        if (model_q.size() != 0) begin
            check({tag, ".empty"}, bus.rx_empty, 1'b0);
            check({tag, ".data"},  bus.rx_data, model_q[0]);
            void'(model_q.pop_front());
        end else begin
            check({tag, ".empty"}, bus.rx_empty, 1'b1);
        end
        bus.rx_rd = 1'b1;
        @(posedge clk); #1 bus.rx_rd = 1'b0;
        @(posedge clk); #1;
        check({tag, ".after"}, bus.rx_empty, (model_q.size() == 0));
        if (model_q.size() != 0) check({tag, ".next"}, bus.rx_data, model_q[0]);
    endtask

    task automatic expect_quiet(input string tag, input int v0, input int f0, input int p0, input int o0);
        check({tag, ".valid"},   n_valid - v0, 0);
        check({tag, ".ferror"},  n_ferr - f0,  0);
        check({tag, ".perror"},  n_perr - p0,  0);
        check({tag, ".overrun"}, n_ovr - o0,   0);
    endtask

    initial begin
        int v0, f0, p0, o0;
        logic [DB-1:0] rd;
        reset = 1'b1; sample_en = 1'b0; rx_en = 1'b1; rxd = 1'b1; bus.rx_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset.empty", bus.rx_empty, 1'b1);
        check("reset.data",  bus.rx_data,  '0);
        check("reset.valid", bus.rx_valid, 1'b0);
        check("reset.ferr",  bus.rx_ferror, 1'b0);
        check("reset.perr",  bus.rx_perror, 1'b0);
        check("reset.ovr",   bus.rx_overrun, 1'b0);
        idle(4);

        do_frame("a5", 8'hA5, 1'b0, 1'b0, -1);
        read_one("a5_rd");
        read_one("empty_rd");

        do_frame("perr", 8'h01, 1'b1, 1'b0, -1);
        do_frame("ferr", 8'h55, 1'b0, 1'b1, -1);
        do_frame("3c", 8'h3C, 1'b0, 1'b0, -1);
        read_one("3c_rd");

        v0 = n_valid; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
        rxd = 1'b0;
        repeat (4) tick();
        idle(24);
        expect_quiet("glitch", v0, f0, p0, o0);
        check("glitch.empty", bus.rx_empty, 1'b1);

        do_frame("spike", 8'hC3, 1'b0, 1'b0, 4);
        read_one("spike_rd");

        for (int i = 0; i <= DEPTH; i++) do_frame("fill", DB'(8'h10 + i), 1'b0, 1'b0, -1);
        for (int i = 0; i <= DEPTH; i++) read_one("drain");

        do_frame("pre_rst", 8'h42, 1'b0, 1'b0, -1);
        send_frame(8'h55, 1'b0, 1'b0, -1, -1, 4);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_q.delete();
        check("rst_mid.empty", bus.rx_empty, 1'b1);
        idle(4);
        do_frame("7e", 8'h7E, 1'b0, 1'b0, -1);
        read_one("7e_rd");

        v0 = n_valid; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
        send_frame(8'h5A, 1'b0, 1'b0, -1, 3, 99);
        idle(2);
        rx_en = 1'b1;
        idle(4);
        expect_quiet("rx_en_drop", v0, f0, p0, o0);
        check("rx_en_drop.empty", bus.rx_empty, 1'b1);
        do_frame("96", 8'h96, 1'b0, 1'b0, -1);
        read_one("96_rd");

        for (int n = 0; n < 36; n++) begin
            rd = DB'($urandom);
            do_frame("rand", rd, ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DB)) : -1);
            repeat ($urandom_range(0, 2)) read_one("rand_rd");
            idle($urandom_range(0, 3));
        end
        while (model_q.size() != 0) read_one("final_rd");
        read_one("final_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
